alu_seq16: RTL and testbench

- Multi-cycle sequencer that runs one external 4-bit ALU slice, four bits per cycle, to perform wide operations.
- The ALU slice has operand inputs A/B, function select S, mode M, carry-in Pin, and outputs R and carry-out Pout.
- Least-significant nibble is processed first. Carry-out from each nibble is registered and fed back as carry-in to the next.
- Sits between the control unit's operand registers and the shared 4-bit ALU; provides a start/busy/done handshake.

---
 rtl/alu_seq16_if.sv | 72 +++++++
 rtl/alu_seq16.sv | 147 ++++++++++++++
 tb/tb_alu_seq16.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq16_if.sv
// alu_seq16_if -- bundle of every non-clock signal of the alu_seq16 sequencer.
//
// Parameter: NIBBLES (4-bit passes per operation), W = 4*NIBBLES.
//
// Signal groups:
//   control side  : start, opa[W], opb[W], sel[4], mode, cin  (into sequencer)
//                   busy, done, res[W], cout, zero            (out of sequencer)
//   ALU slice side: alu_a[4], alu_b[4], alu_s[4], alu_m, alu_pin (out of sequencer)
//                   alu_r[4], alu_pout                          (into sequencer)
//   debug         : state_dbg[2] (current FSM state of the sequencer)
//   step          : single-step qualifier, present only with ALU_SEQ_STEP_EN
//
// Handshake: start is a request that is taken only when the sequencer is idle
// or in its done cycle; there is no ready wire, busy=1 means a request would be
// ignored. done is a one-cycle pulse, and res/cout/zero stay valid from done
// until the next accepted start.
//
// Modports: "master" is the environment (control unit plus the ALU slice),
// "slave" is the sequencer itself.
interface alu_seq16_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic [3:0]   sel;
   logic         mode;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] res;
   logic         cout;
   logic         zero;
   logic [3:0]   alu_a;
   logic [3:0]   alu_b;
   logic [3:0]   alu_s;
   logic         alu_m;
   logic         alu_pin;
   logic [3:0]   alu_r;
   logic         alu_pout;
   logic [1:0]   state_dbg;
`ifdef ALU_SEQ_STEP_EN
   logic         step;

   modport master (
      output start, opa, opb, sel, mode, cin, alu_r, alu_pout, step,
      input  busy, done, res, cout, zero, alu_a, alu_b, alu_s, alu_m, alu_pin,
             state_dbg
   );

   modport slave (
      input  start, opa, opb, sel, mode, cin, alu_r, alu_pout, step,
      output busy, done, res, cout, zero, alu_a, alu_b, alu_s, alu_m, alu_pin,
             state_dbg
   );
`else
   modport master (
      output start, opa, opb, sel, mode, cin, alu_r, alu_pout,
      input  busy, done, res, cout, zero, alu_a, alu_b, alu_s, alu_m, alu_pin,
             state_dbg
   );

   modport slave (
      input  start, opa, opb, sel, mode, cin, alu_r, alu_pout,
      output busy, done, res, cout, zero, alu_a, alu_b, alu_s, alu_m, alu_pin,
             state_dbg
   );
`endif

endinterface

// File: rtl/alu_seq16.sv
// alu_seq16 -- drives an external 4-bit ALU slice one nibble per cycle to build
// a W = 4*NIBBLES bit operation. Least-significant nibble first; the slice's
// carry-out is registered and fed back as carry-in of the next nibble.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : alu_seq16_if.slave (control handshake, operands, result, ALU slice
//          drive/return, state_dbg)
//
// Optional build macro ALU_SEQ_STEP_EN: adds bus.step; in RUN a nibble is
// captured (and the carry/index advanced) only on edges where step=1.
//
// Timing: start accepted at edge 0, RUN in cycles 1..NIBBLES, done=1 in cycle
// NIBBLES+1. A start seen in the done cycle goes straight back to RUN.
module alu_seq16 #(
   parameter int NIBBLES = 4
) (
   input logic       clk,
   input logic       rst,
   alu_seq16_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       state;
   logic [KW-1:0] k;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [3:0]   sel_q;
   logic         mode_q;
   logic         cin_q;
   logic         carry_q;
   logic [W-1:0] res_q;
   logic         cout_q;
   logic         zero_q;
   logic         busy_q;
   logic         done_q;

   logic [W-1:0] res_next;
   logic         advance;
   logic         accept;

`ifdef ALU_SEQ_STEP_EN
   assign advance = bus.step;
`else
   assign advance = 1'b1;
`endif

   assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));

   // The ALU slice sees live nibbles only during RUN; function/mode are the
   // latched values at all times so the slice is stable between operations.
   always_comb begin
      bus.alu_a   = 4'd0;
      bus.alu_b   = 4'd0;
      bus.alu_pin = 1'b0;
      if (state == S_RUN) begin
         bus.alu_a   = a_q[4*int'(k) +: 4];
         bus.alu_b   = b_q[4*int'(k) +: 4];
         bus.alu_pin = (k == '0) ? cin_q : carry_q;
      end
   end

   assign bus.alu_s = sel_q;
   assign bus.alu_m = mode_q;

   // Result with the current nibble merged in; used both for the capture and
   // for the zero flag on the final nibble.
   always_comb begin
      res_next                   = res_q;
      res_next[4*int'(k) +: 4]   = bus.alu_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         k       <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 4'd0;
         mode_q  <= 1'b0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (accept) begin
                  a_q    <= bus.opa;
                  b_q    <= bus.opb;
                  sel_q  <= bus.sel;
                  mode_q <= bus.mode;
                  cin_q  <= bus.cin;
                  k      <= '0;
                  busy_q <= 1'b1;
                  state  <= S_RUN;
               end else begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            S_RUN: begin
               if (advance) begin
                  res_q   <= res_next;
                  carry_q <= bus.alu_pout;
                  if (k == K_LAST) begin
                     k      <= '0;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     cout_q <= bus.alu_pout;
                     zero_q <= (res_next == '0);
                     state  <= S_DONE;
                  end else begin
                     k <= k + 1'b1;
                  end
               end
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.res       = res_q;
   assign bus.cout      = cout_q;
   assign bus.zero      = zero_q;
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16 -- directed bench for alu_seq16 with a 4-bit adder ALU stub
// (R = A + B + Pin mod 16, POUT = carry-out). Optional STEP test is compiled
// in only with ALU_SEQ_STEP_EN.
module tb_alu_seq16;
   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   logic [3:0] exp_q[$];

   alu_seq16_if #(.NIBBLES(NIBBLES)) bus ();

   alu_seq16 #(.NIBBLES(NIBBLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ALU slice stub
   logic [4:0] alu_sum;
   assign alu_sum      = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_pin};
   assign bus.alu_r    = alu_sum[3:0];
   assign bus.alu_pout = alu_sum[4];

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drive one request for a single accepting edge, then drop start
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] s, input logic m, input logic c);
      bus.opa   = a;
      bus.opb   = b;
      bus.sel   = s;
      bus.mode  = m;
      bus.cin   = c;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.opa   = '0;
      bus.opb   = '0;
      bus.sel   = 4'd0;
      bus.mode  = 1'b0;
      bus.cin   = 1'b0;
`ifdef ALU_SEQ_STEP_EN
      bus.step  = 1'b1;
`endif
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_done",  32'(bus.done), 32'd0);
      check("rst_res",   32'(bus.res),  32'd0);
      check("rst_cout",  32'(bus.cout), 32'd0);
      check("rst_zero",  32'(bus.zero), 32'd0);
      check("rst_alu_s", 32'(bus.alu_s), 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'd0);
      tick();
      check("idle_done", 32'(bus.done), 32'd0);

      // 1: 0FFF + 0001 -> 1000, busy for 4 cycles, done in cycle 5
      start_op(16'h0FFF, 16'h0001, 4'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("t1_busy%0d", i), 32'(bus.busy), 32'd1);
         check($sformatf("t1_nodone%0d", i), 32'(bus.done), 32'd0);
         tick();
      end
      check("t1_done", 32'(bus.done), 32'd1);
      check("t1_busy_off", 32'(bus.busy), 32'd0);
      check("t1_res",  32'(bus.res),  32'h1000);
      check("t1_cout", 32'(bus.cout), 32'd0);
      check("t1_zero", 32'(bus.zero), 32'd0);
      check("t1_alu_a_done", 32'(bus.alu_a), 32'd0);
      tick();
      check("t1_done_pulse", 32'(bus.done), 32'd0);
      check("t1_res_hold", 32'(bus.res), 32'h1000);

      // 2: FFFF + 0001 -> 0000, pin 0,1,1,1, cout 1, zero 1
      exp_q.push_back(4'd0);
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd1);
      start_op(16'hFFFF, 16'h0001, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_pin%0d", i), 32'(bus.alu_pin), 32'(exp_q.pop_front()));
         tick();
      end
      check("t2_done", 32'(bus.done), 32'd1);
      check("t2_res",  32'(bus.res),  32'h0000);
      check("t2_cout", 32'(bus.cout), 32'd1);
      check("t2_zero", 32'(bus.zero), 32'd1);
      tick();
      check("t2_cout_hold", 32'(bus.cout), 32'd1);
      check("t2_zero_hold", 32'(bus.zero), 32'd1);

      // 3: latched sel/mode/opa survive input changes during RUN
      start_op(16'h1234, 16'h0101, 4'b1001, 1'b1, 1'b0);
      bus.sel  = 4'd0;
      bus.mode = 1'b0;
      bus.opa  = 16'hFFFF;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_alu_s%0d", i), 32'(bus.alu_s), 32'h9);
         check($sformatf("t3_alu_m%0d", i), 32'(bus.alu_m), 32'd1);
         tick();
      end
      check("t3_done", 32'(bus.done), 32'd1);
      check("t3_res",  32'(bus.res),  32'h1335);
      check("t3_alu_s_done", 32'(bus.alu_s), 32'h9);
      tick();

      // 4: start held high -> done every 5 cycles, res 2346
      bus.opa   = 16'h1234;
      bus.opb   = 16'h1111;
      bus.cin   = 1'b1;
      bus.start = 1'b1;
      tick();
      for (int c = 1; c <= 15; c++) begin
         check($sformatf("t4_done_c%0d", c), 32'(bus.done), ((c % 5) == 0) ? 32'd1 : 32'd0);
         check($sformatf("t4_busy_c%0d", c), 32'(bus.busy), ((c % 5) == 0) ? 32'd0 : 32'd1);
         if ((c % 5) == 0) check($sformatf("t4_res_c%0d", c), 32'(bus.res), 32'h2346);
         if (c == 15) bus.start = 1'b0;
         tick();
      end
      check("t4_idle_busy", 32'(bus.busy), 32'd0);
      check("t4_idle_res",  32'(bus.res),  32'h2346);
      check("t4_idle_cout", 32'(bus.cout), 32'd0);

      // 5: reset in the 2nd RUN cycle aborts with no later done
      start_op(16'h0FFF, 16'h0001, 4'd0, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy",  32'(bus.busy), 32'd0);
      check("t5_done",  32'(bus.done), 32'd0);
      check("t5_res",   32'(bus.res),  32'd0);
      check("t5_cout",  32'(bus.cout), 32'd0);
      check("t5_state", 32'(bus.state_dbg), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("t5_nodone%0d", i), 32'(bus.done), 32'd0);
      end

`ifdef ALU_SEQ_STEP_EN
      // 6: step on alternate cycles -> busy 8 cycles, res 0100
      bus.step = 1'b0;
      start_op(16'h00FF, 16'h0001, 4'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         bus.step = ((i % 2) == 0);
         check($sformatf("t6_busy%0d", i), 32'(bus.busy), 32'd1);
         check($sformatf("t6_alu_a%0d", i), 32'(bus.alu_a),
               (((i - 1) / 2) < 2) ? 32'hF : 32'h0);
         tick();
      end
      bus.step = 1'b1;
      check("t6_done", 32'(bus.done), 32'd1);
      check("t6_res",  32'(bus.res),  32'h0100);
      check("t6_cout", 32'(bus.cout), 32'd0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
